riscv_lsu: RTL and testbench
============================

# riscv_lsu

Load/store unit sitting directly upstream of the RISC-V data memory. It accepts one load or store request at a time from the MEM pipeline stage over a valid/ready handshake. It turns the request into one or two word-aligned memory accesses with byte strobes, then returns sign- or zero-extended load data, or store completion, over a valid/ready response channel. Accesses that cross a word boundary are split into two sequential accesses.

## Interface
Parameters:
- XLEN, 32, data/address width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  LSU can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, LSB-justified.
- req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- resp_valid  out  1  response present; held until taken.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_fault  out  1  misaligned (macro off) or illegal funct3.
- mem_addr  out  32  word-aligned address (bits [1:0] = 0).
- mem_wdata  out  32  lane-shifted store data.
- mem_wstrb  out  4  byte write strobes.
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- mem_rdata  in  32  memory read data, combinational from mem_addr in the same cycle.

## Operation
- States:
  - IDLE: req_ready = 1. Handshake on req_valid & req_ready. Capture write, addr, wdata and funct3. Then:
    - go to FAULT if the request is illegal;
    - otherwise go to ACC0.
  - ACC0: drive the access to word addr & ~3, with mem_read or mem_write set.
    - For loads, capture the in-use lanes of mem_rdata at the clock edge.
    - Go to ACC1 if the access crosses a word boundary, else go to RESP.
  - ACC1: drive the access to word (addr & ~3) + 4 with the remaining lanes; capture the read lanes; go to RESP.
  - RESP: resp_valid = 1. When resp_ready is high, go to IDLE.
  - FAULT: resp_valid = 1, resp_fault = 1, resp_rdata = 0. When resp_ready is high, go to IDLE.
- Size comes from funct3[1:0]: 0 = byte, 1 = half, 2 = word. Any other size is illegal.
- Loads: funct3[2] = 1 selects zero-extension. funct3 = 3'b110 and 3'b111 are illegal.
- Stores: funct3[2] = 1 is illegal.
- A request crosses a word boundary when (addr[1:0] + bytes) > 4.
- Lane mapping:
  - Request byte k goes to memory lane (addr[1:0] + k) mod 4.
  - Lanes past lane 3 wrap into the second access, starting at lane 0.
  - mem_wstrb marks only the used lanes in each access.
- In non-access states, mem_read, mem_write, mem_wstrb and mem_wdata are all 0.
- Arithmetic: the second word address wraps modulo 2^32, so 0xFFFFFFFC + 4 = 0x00000000.

## Timing
- Reset value of every output: req_ready = 1 (IDLE), all others 0. Reset also clears the captured request and data registers.
- Reset asserted mid-operation (any state): return to IDLE immediately. No further memory strobes; any pending response is discarded.
- Latency, with the request accepted at edge T:
  - non-crossing access: ACC0 in cycle T+1, resp_valid in T+2;
  - crossing access: ACC0 in T+1, ACC1 in T+2, resp_valid in T+3;
  - fault: resp_valid in T+1, with no memory strobe.
- While resp_ready = 0, resp_valid, resp_rdata and resp_fault hold stable.
- req_ready stays 0 from acceptance until the response handshake completes.
- Response handshake at edge E: req_ready = 1 in cycle E+1. There is no same-cycle turnaround.

## Configuration
- RISCV_LSU_MISALIGN_EN defined:
  - all misaligned halfword and word accesses complete;
  - crossing accesses are split as above;
  - a halfword at addr[1:0] = 1 is a single access on lanes 1–2.
- RISCV_LSU_MISALIGN_EN undefined:
  - the following take the FAULT path: halfword with addr[0] ≠ 0, word with addr[1:0] ≠ 0;
  - ACC1 is unreachable and may be omitted.

## Structure
- Package riscv_lsu_pkg holds:
  - funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW);
  - the state enum lsu_state_t (IDLE, ACC0, ACC1, RESP, FAULT);
  - the size encoding.
- Sub-module riscv_lsu_align, combinational:
  - store lane shift and strobe generation per access;
  - load byte gather and sign/zero extension.
- riscv_lsu contains the FSM and the capture registers.

## Test plan
Preload memory word 0x100 = 0x44332211 and word 0x104 = 0xF8776655.
- LB at 0x107 → resp_rdata 0xFFFFFFF8. LBU at 0x107 → 0x000000F8. Each response arrives 2 cycles after acceptance.
- LW at 0x102, macro on → mem_read at 0x100, then at 0x104; resp_rdata 0x66554433 at T+3.
- LW at 0x102, macro off → resp_fault = 1 at T+1, resp_rdata 0, mem_read never asserted.
- SH at 0x103 with wdata 0x0000ABCD, macro on:
  - first access: mem_addr 0x100, wstrb 4'b1000, wdata[31:24] = 0xCD;
  - second access: mem_addr 0x104, wstrb 4'b0001, wdata[7:0] = 0xAB;
  - readback LW 0x100 = 0xCD332211.
- SW at 0x108 with resp_ready held 0 for 3 cycles → resp_valid stable and req_ready 0 throughout. req_ready returns to 1 the cycle after the handshake.
- LW at 0x102 (macro on) with rst pulsed during ACC1 → req_ready = 1 immediately, resp_valid 0, no further mem_read.

Source files
------------

// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu_pkg: shared definitions for the RISC-V load/store unit.
//   - funct3 encodings for loads and stores
//   - lsu_state_t: FSM state encoding
//   - lsu_size_t : access size taken from funct3[1:0]
//   - helpers: byte count, lane mask, strobe expansion, legality check
package riscv_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACC0  = 3'd1,
    ACC1  = 3'd2,
    RESP  = 3'd3,
    FAULT = 3'd4
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_BAD  = 2'd3
  } lsu_size_t;

  // Number of bytes moved by an access of the given size.
  function automatic logic [2:0] size_bytes(input lsu_size_t s);
    case (s)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      SZ_WORD: size_bytes = 3'd4;
      default: size_bytes = 3'd0;
    endcase
  endfunction

  // Lane mask of an access starting at lane 0.
  function automatic logic [3:0] size_mask(input lsu_size_t s);
    case (s)
      SZ_BYTE: size_mask = 4'b0001;
      SZ_HALF: size_mask = 4'b0011;
      SZ_WORD: size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  endfunction

  // Expand a 4-bit byte strobe into a 32-bit bit mask.
  function automatic logic [31:0] strb_to_bits(input logic [3:0] s);
    strb_to_bits = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  // Illegal funct3 for the direction, or a misalignment the build cannot split.
  function automatic logic req_illegal(input logic       write,
                                       input logic [2:0] f3,
                                       input logic [1:0] off,
                                       input logic       misalign_en);
    logic bad_f3;
    logic bad_align;
    bad_f3    = (f3[1:0] == 2'b11) || (write && f3[2]) || (!write && (f3 == 3'b110));
    bad_align = !misalign_en &&
                (((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00)));
    req_illegal = bad_f3 || bad_align;
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// riscv_lsu_align: combinational lane steering for the LSU.
//   Store side: shifts LSB-justified store data into memory lanes and builds
//   the lane mask for the first (i_second=0) or second (i_second=1) access.
//   Load side: gathers the request bytes from the two captured words and
//   sign- or zero-extends them.
// Ports:
//   i_off    byte offset addr[1:0]       i_size  access size
//   i_second selects second access       i_wdata LSB-justified store data
//   i_zext   1 = zero-extend loads       i_rd_lo/i_rd_hi captured words
//   o_wdata  lane-shifted store data     o_strb  lane mask of this access
//   o_rdata  extended load data
module riscv_lsu_align
  import riscv_lsu_pkg::*;
(
  input  logic [1:0]  i_off,
  input  lsu_size_t   i_size,
  input  logic        i_second,
  input  logic [31:0] i_wdata,
  input  logic        i_zext,
  input  logic [31:0] i_rd_lo,
  input  logic [31:0] i_rd_hi,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_strb,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_mask8;
  logic [63:0] w_wide;
  logic [31:0] w_low;

  // Eight virtual lanes: lanes 0-3 are the first word, lanes 4-7 the second.
  always_comb begin
    w_mask8 = 8'({4'b0000, size_mask(i_size)} << i_off);
    w_wide  = {32'd0, i_wdata} << {i_off, 3'b000};
    if (i_second) begin
      o_strb  = w_mask8[7:4];
      o_wdata = w_wide[63:32];
    end else begin
      o_strb  = w_mask8[3:0];
      o_wdata = w_wide[31:0];
    end
  end

  // Gather request bytes back to bit 0 and extend to 32 bits.
  always_comb begin
    w_low = 32'({i_rd_hi, i_rd_lo} >> {i_off, 3'b000});
    case (i_size)
      SZ_BYTE: o_rdata = i_zext ? {24'd0, w_low[7:0]}  : {{24{w_low[7]}}, w_low[7:0]};
      SZ_HALF: o_rdata = i_zext ? {16'd0, w_low[15:0]} : {{16{w_low[15]}}, w_low[15:0]};
      SZ_WORD: o_rdata = w_low;
      default: o_rdata = 32'd0;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit in front of the data memory.
// Accepts one request at a time, issues one or two word-aligned accesses,
// and returns extended load data, store completion or a fault.
// Build option: define RISCV_LSU_MISALIGN_EN to split misaligned half/word
// accesses across words; otherwise they respond with a fault.
// Ports:
//   clk, rst (async, active-high)
//   req_valid/req_ready, req_write, req_addr, req_wdata, req_funct3
//   resp_valid/resp_ready, resp_rdata, resp_fault
//   mem_addr, mem_wdata, mem_wstrb, mem_read, mem_write, mem_rdata
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [2:0]      req_funct3,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_fault,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  output logic            mem_read,
  output logic            mem_write,
  input  logic [XLEN-1:0] mem_rdata
);

`ifdef RISCV_LSU_MISALIGN_EN
  localparam logic LP_MISALIGN_EN = 1'b1;
`else
  localparam logic LP_MISALIGN_EN = 1'b0;
`endif

  lsu_state_t  r_state;
  lsu_state_t  w_next;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_f3;
  logic [31:0] r_word0;
  logic [31:0] r_word1;

  lsu_size_t   w_size;
  logic [2:0]  w_end;
  logic        w_cross;
  logic [31:0] w_base;
  logic [31:0] w_lane_wdata;
  logic [3:0]  w_lane_strb;
  logic [31:0] w_ext_rdata;

  assign w_size  = lsu_size_t'(r_f3[1:0]);
  // One past the last lane used; beyond lane 4 the access spills into the next word.
  assign w_end   = {1'b0, r_addr[1:0]} + size_bytes(w_size);
  assign w_cross = (w_end > 3'd4);
  assign w_base  = {r_addr[31:2], 2'b00};

  riscv_lsu_align u_align (
    .i_off    (r_addr[1:0]),
    .i_size   (w_size),
    .i_second (r_state == ACC1),
    .i_wdata  (r_wdata),
    .i_zext   (r_f3[2]),
    .i_rd_lo  (r_word0),
    .i_rd_hi  (r_word1),
    .o_wdata  (w_lane_wdata),
    .o_strb   (w_lane_strb),
    .o_rdata  (w_ext_rdata)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_next = req_illegal(req_write, req_funct3, req_addr[1:0], LP_MISALIGN_EN) ? FAULT : ACC0;
        end else begin
          w_next = IDLE;
        end
      end
      ACC0: begin
        if (LP_MISALIGN_EN && w_cross) begin
          w_next = ACC1;
        end else begin
          w_next = RESP;
        end
      end
      ACC1:  w_next = RESP;
      RESP, FAULT: begin
        if (resp_ready) begin
          w_next = IDLE;
        end else begin
          w_next = r_state;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Request capture and per-access load lane capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_f3    <= 3'd0;
      r_word0 <= 32'd0;
      r_word1 <= 32'd0;
    end else if ((r_state == IDLE) && req_valid) begin
      r_write <= req_write;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_f3    <= req_funct3;
      r_word0 <= 32'd0;
      r_word1 <= 32'd0;
    end else if ((r_state == ACC0) && !r_write) begin
      r_word0 <= mem_rdata & strb_to_bits(w_lane_strb);
    end else if ((r_state == ACC1) && !r_write) begin
      r_word1 <= mem_rdata & strb_to_bits(w_lane_strb);
    end else begin
      r_word0 <= r_word0;
    end
  end

  // Memory port drive; everything is zero outside the access states.
  always_comb begin
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_wstrb = 4'b0000;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if ((r_state == ACC0) || (r_state == ACC1)) begin
      // Second word address wraps naturally at 2^32.
      mem_addr = (r_state == ACC1) ? (w_base + 32'd4) : w_base;
      if (r_write) begin
        mem_write = 1'b1;
        mem_wstrb = w_lane_strb;
        mem_wdata = w_lane_wdata;
      end else begin
        mem_read  = 1'b1;
      end
    end else begin
      mem_addr = 32'd0;
    end
  end

  // Handshake and response outputs decoded from the registered state.
  always_comb begin
    req_ready  = (r_state == IDLE);
    resp_valid = (r_state == RESP) || (r_state == FAULT);
    resp_fault = (r_state == FAULT);
    if ((r_state == RESP) && !r_write) begin
      resp_rdata = w_ext_rdata;
    end else begin
      resp_rdata = 32'd0;
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: directed scenarios followed by random
// requests, checked against a byte-addressed reference memory model.
module tb_riscv_lsu;

`ifdef RISCV_LSU_MISALIGN_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  // Memory behind the DUT (aliases every 1 KiB) and the reference byte image.
  logic [31:0] dmem [256] = '{default: 32'd0};
  logic [7:0]  ref_bytes [1024] = '{default: 8'd0};
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_data;

  riscv_lsu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = dmem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_write) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_wstrb[i]) dmem[mem_addr[9:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end else if (pl_en) begin
      dmem[pl_idx] <= pl_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_fault(input bit w, input logic [2:0] f3, input logic [31:0] a);
    int sz = int'(f3[1:0]);
    if (sz == 3) return 1'b1;
    if (w && f3[2]) return 1'b1;
    if (!w && f3[2] && sz == 2) return 1'b1;
    if (!MIS && sz == 1 && a[0]) return 1'b1;
    if (!MIS && sz == 2 && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    int n = 1 << int'(f3[1:0]);
    logic [31:0] v = 32'd0;
    logic [31:0] b;
    for (int k = 0; k < n; k++) begin
      b = a + 32'(k);
      v[8*k +: 8] = ref_bytes[b[9:0]];
    end
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  // One request/response transaction checked against the reference model.
  task automatic do_txn(input bit w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] o_rd, output logic o_flt);
    bit flt;
    int n;
    int lat;
    int rd_cnt;
    int wr_cnt;
    logic [31:0] b;
    logic [31:0] wa;
    logic [31:0] tmp;
    logic [31:0] erd;
    logic [31:0] ea[$];
    logic [3:0]  es[$];
    logic [31:0] ew[$];
    logic [31:0] oa[$];
    logic [3:0]  os[$];
    logic [31:0] ow[$];
    logic [31:0] hold_rd;
    logic        hold_flt;

    flt = model_fault(w, f3, a);
    n   = 1 << int'(f3[1:0]);
    erd = 32'd0;
    if (!flt) begin
      for (int k = 0; k < n; k++) begin
        b  = a + 32'(k);
        wa = {b[31:2], 2'b00};
        if (ea.size() == 0 || ea[ea.size()-1] != wa) begin
          ea.push_back(wa);
          es.push_back(4'b0000);
          ew.push_back(32'd0);
        end
        es[ea.size()-1] = es[ea.size()-1] | (4'b0001 << b[1:0]);
        tmp = ew[ea.size()-1];
        tmp[8*b[1:0] +: 8] = wd[8*k +: 8];
        ew[ea.size()-1] = tmp;
      end
      if (!w) erd = model_load(f3, a);
    end

    @(negedge clk);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_funct3 = f3;
    @(posedge clk);
    #1 req_valid = 1'b0;

    lat = 0; rd_cnt = 0; wr_cnt = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (mem_read)  rd_cnt++;
      if (mem_write) wr_cnt++;
      if (mem_read || mem_write) begin
        oa.push_back(mem_addr); os.push_back(mem_wstrb); ow.push_back(mem_wdata);
      end
      if (resp_valid || lat >= 8) break;
      chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
    end
    chk("latency", 32'(lat), flt ? 32'd1 : 32'(1 + ea.size()));
    chk("resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("resp_fault", {31'd0, resp_fault}, {31'd0, flt});
    chk("resp_rdata", resp_rdata, erd);
    chk("mem_read_cnt", 32'(rd_cnt), (!flt && !w) ? 32'(ea.size()) : 32'd0);
    chk("mem_write_cnt", 32'(wr_cnt), (!flt && w) ? 32'(ea.size()) : 32'd0);
    if (oa.size() == ea.size()) begin
      for (int j = 0; j < ea.size(); j++) begin
        chk("mem_addr", oa[j], ea[j]);
        if (w) begin
          chk("mem_wstrb", {28'd0, os[j]}, {28'd0, es[j]});
          chk("mem_wdata", ow[j] & {{8{os[j][3]}}, {8{os[j][2]}}, {8{os[j][1]}}, {8{os[j][0]}}}, ew[j]);
        end
      end
    end
    o_rd = resp_rdata; o_flt = resp_fault;

    hold_rd = resp_rdata; hold_flt = resp_fault;
    resp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("hold_rdata", resp_rdata, hold_rd);
      chk("hold_fault", {31'd0, resp_fault}, {31'd0, hold_flt});
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    chk("post_hs_req_ready", {31'd0, req_ready}, 32'd1);
    chk("post_hs_resp_valid", {31'd0, resp_valid}, 32'd0);

    if (!flt && w) begin
      for (int k = 0; k < n; k++) begin
        b = a + 32'(k);
        ref_bytes[b[9:0]] = wd[8*k +: 8];
      end
    end
  endtask

  logic [31:0] rd;
  logic        flt;
  logic [31:0] ra;
  logic [31:0] mw;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0;
    req_wdata = 32'd0; req_funct3 = 3'd0; resp_ready = 1'b0;
    pl_en = 1'b0; pl_idx = 8'd0; pl_data = 32'd0;

    // Preload words 0x100 and 0x104 while reset is held.
    @(negedge clk);
    pl_en = 1'b1; pl_idx = 8'h40; pl_data = 32'h4433_2211;
    @(negedge clk);
    pl_idx = 8'h41; pl_data = 32'hF877_6655;
    @(negedge clk);
    pl_en = 1'b0;
    {ref_bytes[259], ref_bytes[258], ref_bytes[257], ref_bytes[256]} = 32'h4433_2211;
    {ref_bytes[263], ref_bytes[262], ref_bytes[261], ref_bytes[260]} = 32'hF877_6655;

    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_fault", {31'd0, resp_fault}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_strobes", {28'd0, mem_read, mem_write, mem_wstrb == 4'b0000, 1'b0}, 32'd2);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;

    do_txn(1'b0, 3'b000, 32'h107, 32'd0, 0, rd, flt);
    chk("lb_107", rd, 32'hFFFF_FFF8);
    do_txn(1'b0, 3'b100, 32'h107, 32'd0, 0, rd, flt);
    chk("lbu_107", rd, 32'h0000_00F8);
    do_txn(1'b0, 3'b010, 32'h102, 32'd0, 0, rd, flt);
`ifdef RISCV_LSU_MISALIGN_EN
    chk("lw_102", rd, 32'h6655_4433);
`else
    chk("lw_102_fault", {31'd0, flt}, 32'd1);
`endif
    do_txn(1'b1, 3'b001, 32'h103, 32'h0000_ABCD, 0, rd, flt);
    do_txn(1'b0, 3'b010, 32'h100, 32'd0, 0, rd, flt);
`ifdef RISCV_LSU_MISALIGN_EN
    chk("lw_100_after_sh", rd, 32'hCD33_2211);
`else
    chk("lw_100_after_sh", rd, 32'h4433_2211);
`endif
    do_txn(1'b1, 3'b010, 32'h108, 32'h1234_5678, 3, rd, flt);
    do_txn(1'b0, 3'b010, 32'h108, 32'd0, 0, rd, flt);
    chk("lw_108", rd, 32'h1234_5678);
    // Top-of-address-space accesses, wrapping to word 0 when split.
    do_txn(1'b1, 3'b010, 32'hFFFF_FFFE, 32'hA1B2_C3D4, 1, rd, flt);
    do_txn(1'b0, 3'b001, 32'hFFFF_FFFF, 32'd0, 0, rd, flt);
    do_txn(1'b0, 3'b101, 32'h0000_0000, 32'd0, 0, rd, flt);
    // Illegal funct3 values.
    do_txn(1'b0, 3'b110, 32'h100, 32'd0, 1, rd, flt);
    do_txn(1'b0, 3'b011, 32'h100, 32'd0, 0, rd, flt);
    do_txn(1'b1, 3'b100, 32'h100, 32'hFFFF_FFFF, 0, rd, flt);
    chk("illegal_store_fault", {31'd0, flt}, 32'd1);

    // Reset pulsed mid-transaction.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h102; req_funct3 = 3'b010;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
`ifdef RISCV_LSU_MISALIGN_EN
    @(negedge clk);
    chk("acc1_mem_read", {31'd0, mem_read}, 32'd1);
    chk("acc1_mem_addr", mem_addr, 32'h104);
`else
    chk("fault_before_rst", {31'd0, resp_fault}, 32'd1);
`endif
    #2 rst = 1'b1;
    #1;
    chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("midrst_mem_read", {31'd0, mem_read}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("postrst_quiet", {29'd0, mem_read, mem_write, resp_valid}, 32'd0);
    end

    // Random requests.
    for (int t = 0; t < 80; t++) begin
      ra = ($urandom_range(0, 3) == 0) ? $urandom : (32'h200 + 32'($urandom_range(0, 31)));
      do_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom,
             $urandom_range(0, 2), rd, flt);
    end

    // Final memory image against the reference bytes.
    for (int i = 0; i < 256; i++) begin
      mw = {ref_bytes[4*i+3], ref_bytes[4*i+2], ref_bytes[4*i+1], ref_bytes[4*i]};
      chk("mem_image", dmem[i], mw);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
